// File: rtl/csr_hpm_counters.sv
// Machine/user performance counters with programmable event selection.
// Sticky overflow flags drive a registered interrupt request.
module csr_hpm_counters #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instret_incr_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  we_i,
    input  logic [11:0]           waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [11:0]           raddr_i,
    output logic [31:0]           rdata_o,
    output logic                  rhit_o,
    output logic                  ovf_irq_o
);
    localparam int HW = CNT_WIDTH - 32;

    function automatic logic [31:0] impl_mask();
        logic [31:0] m;
        m = 32'h5;
        for (int i = 3; i < 32; i++)
            if (i < 3 + NUM_HPM) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [31:0] IMPL = impl_mask();

    logic [CNT_WIDTH-1:0] cnt_q [32];
    logic [CNT_WIDTH-1:0] cnt_d [32];
    logic [4:0]           sel_q [32];
    logic [31:0]          inh_q;
    logic [31:0]          ovf_q;
    logic [31:0]          ovfen_q;
    logic [31:0]          inc;
    logic [31:0]          wrap;
    logic [31:0]          ev_pad;
    logic                 irq_q;

    logic [4:0] widx;
    logic [6:0] wreg;
    logic       w_lo;
    logic       w_hi;
    logic       w_ev;
    logic       w_inh;
    logic       w_ovf;
    logic       w_ovfen;

    assign widx    = waddr_i[4:0];
    assign wreg    = waddr_i[11:5];
    assign w_lo    = we_i && wreg == 7'h58 && IMPL[widx];
    assign w_hi    = we_i && wreg == 7'h5C && IMPL[widx];
    assign w_ev    = we_i && wreg == 7'h19 && widx >= 5'd3 && IMPL[widx];
    assign w_inh   = we_i && waddr_i == 12'h320;
    assign w_ovf   = we_i && waddr_i == 12'h7C0;
    assign w_ovfen = we_i && waddr_i == 12'h7C1;

    // Bit 0 padded low so selector 0 and out-of-range selectors count nothing
    assign ev_pad = 32'(event_i) << 1;

    always_comb begin
        inc = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 0)      inc[i] = 1'b1;
            else if (i == 2) inc[i] = instret_incr_i;
            else             inc[i] = ev_pad[sel_q[i]];
        end
        inc = inc & IMPL & ~inh_q;
    end

    always_comb begin
        wrap = '0;
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (w_lo && widx == 5'(i)) begin
                cnt_d[i][31:0] = wdata_i;
            end else if (w_hi && widx == 5'(i)) begin
                cnt_d[i][CNT_WIDTH-1:32] = wdata_i[HW-1:0];
            end else if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
                wrap[i]  = &cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            inh_q   <= '0;
            ovf_q   <= '0;
            ovfen_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++)
                cnt_q[i] <= IMPL[i] ? cnt_d[i] : '0;
            if (w_ev)    sel_q[widx] <= wdata_i[4:0];
            if (w_inh)   inh_q <= wdata_i & IMPL;
            if (w_ovfen) ovfen_q <= wdata_i & IMPL;
            // Hardware set is OR-ed after the clear so it wins
            ovf_q <= ((w_ovf ? (ovf_q & ~wdata_i) : ovf_q) | wrap) & IMPL;
            irq_q <= |(ovf_q & ovfen_q);
        end
    end

    assign ovf_irq_o = irq_q;

    logic [4:0]  ridx;
    logic [63:0] ext;
    logic        rwr;

    assign ridx = raddr_i[4:0];
    assign ext  = 64'(cnt_q[ridx]);

    always_comb begin
        rhit_o  = 1'b0;
        rdata_o = '0;
        case (raddr_i[11:5])
            7'h58, 7'h60: if (IMPL[ridx]) begin
                rhit_o  = 1'b1;
                rdata_o = ext[31:0];
            end
            7'h5C, 7'h64: if (IMPL[ridx]) begin
                rhit_o  = 1'b1;
                rdata_o = ext[63:32];
            end
            7'h19: if (ridx == 5'd0) begin
                rhit_o  = 1'b1;
                rdata_o = inh_q;
            end else if (ridx >= 5'd3 && IMPL[ridx]) begin
                rhit_o  = 1'b1;
                rdata_o = {27'd0, sel_q[ridx]};
            end
            7'h3E: if (ridx == 5'd0) begin
                rhit_o  = 1'b1;
                rdata_o = ovf_q;
            end else if (ridx == 5'd1) begin
                rhit_o  = 1'b1;
                rdata_o = ovfen_q;
            end
            default: ;
        endcase
        rwr = rhit_o && raddr_i[11:8] != 4'hC;
        if (rwr && we_i && waddr_i == raddr_i) rdata_o = wdata_i;
    end
endmodule

// File: tb/tb_csr_hpm_counters.sv
// Directed bench for csr_hpm_counters at default parameters.
// Each scenario task drives vectors and compares against hand-computed values.
module tb_csr_hpm_counters;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instret_incr_i;
    logic [7:0]  event_i;
    logic        we_i;
    logic [11:0] waddr_i;
    logic [31:0] wdata_i;
    logic [11:0] raddr_i;
    logic [31:0] rdata_o;
    logic        rhit_o;
    logic        ovf_irq_o;

    int vecs = 0;
    int errs = 0;

    csr_hpm_counters dut (
        .clk_i(clk_i), .rst_i(rst_i), .instret_incr_i(instret_incr_i),
        .event_i(event_i), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
        .rhit_o(rhit_o), .ovf_irq_o(ovf_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        we_i = 1'b1;
        waddr_i = a;
        wdata_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        raddr_i = a;
        #1;
        d = rdata_o;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_i = 1'b1;
        we_i = 1'b1; waddr_i = 12'hB00; wdata_i = 32'h5;
        step();
        step();
        we_i = 1'b0;
        rd(12'hB00, v); vecs++;
        if (v !== 32'd0) begin errs++; $display("FAIL rst_mcycle got %h want %h", v, 32'd0); end
        rd(12'h320, v); vecs++;
        if (v !== 32'd0) begin errs++; $display("FAIL rst_inhibit got %h want %h", v, 32'd0); end
        vecs++;
        if (ovf_irq_o !== 1'b0) begin errs++; $display("FAIL rst_irq got %b want 0", ovf_irq_o); end
        rst_i = 1'b0;
        step();
        rd(12'hB00, v); vecs++;
        if (v !== 32'd1) begin errs++; $display("FAIL release_mcycle got %h want %h", v, 32'd1); end
        repeat (9) step();
        rd(12'hB00, v); vecs++;
        if (v !== 32'd10) begin errs++; $display("FAIL mcycle_10 got %h want %h", v, 32'd10); end
        rd(12'hC00, v); vecs++;
        if (v !== 32'd10) begin errs++; $display("FAIL cycle_shadow got %h want %h", v, 32'd10); end
        rd(12'hB02, v); vecs++;
        if (v !== 32'd0) begin errs++; $display("FAIL minstret_0 got %h want %h", v, 32'd0); end
        vecs++;
        if (ovf_irq_o !== 1'b0) begin errs++; $display("FAIL idle_irq got %b want 0", ovf_irq_o); end
    endtask

    task automatic test_event();
        logic [31:0] v;
        event_i = 8'h01;
        wr(12'h323, 32'hFFFF_FFE2);
        rd(12'h323, v); vecs++;
        if (v !== 32'h2) begin errs++; $display("FAIL evsel_rd got %h want %h", v, 32'h2); end
        event_i = 8'h03;
        repeat (5) step();
        event_i = 8'h01;
        rd(12'hB03, v); vecs++;
        if (v !== 32'd5) begin errs++; $display("FAIL hpm3_cnt got %h want %h", v, 32'd5); end
        step();
        rd(12'hC03, v); vecs++;
        if (v !== 32'd5) begin errs++; $display("FAIL hpm3_ignore got %h want %h", v, 32'd5); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        wr(12'h7C1, 32'h8);
        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        rd(12'hB03, v); vecs++;
        if (v !== 32'hFFFF_FFFF) begin errs++; $display("FAIL ones_lo got %h want %h", v, 32'hFFFF_FFFF); end
        rd(12'hB83, v); vecs++;
        if (v !== 32'hFFFF_FFFF) begin errs++; $display("FAIL ones_hi got %h want %h", v, 32'hFFFF_FFFF); end
        event_i = 8'h03;
        step();
        event_i = 8'h01;
        rd(12'hB03, v); vecs++;
        if (v !== 32'd0) begin errs++; $display("FAIL wrap_lo got %h want %h", v, 32'd0); end
        rd(12'hB83, v); vecs++;
        if (v !== 32'd0) begin errs++; $display("FAIL wrap_hi got %h want %h", v, 32'd0); end
        rd(12'h7C0, v); vecs++;
        if (v !== 32'h8) begin errs++; $display("FAIL ovf_set got %h want %h", v, 32'h8); end
        vecs++;
        if (ovf_irq_o !== 1'b0) begin errs++; $display("FAIL irq_early got %b want 0", ovf_irq_o); end
        step();
        vecs++;
        if (ovf_irq_o !== 1'b1) begin errs++; $display("FAIL irq_rise got %b want 1", ovf_irq_o); end
        wr(12'h7C0, 32'h8);
        rd(12'h7C0, v); vecs++;
        if (v !== 32'h0) begin errs++; $display("FAIL ovf_clr got %h want %h", v, 32'h0); end
        vecs++;
        if (ovf_irq_o !== 1'b1) begin errs++; $display("FAIL irq_hold got %b want 1", ovf_irq_o); end
        step();
        vecs++;
        if (ovf_irq_o !== 1'b0) begin errs++; $display("FAIL irq_drop got %b want 0", ovf_irq_o); end
        // Wrap and clear in the same edge: the set must survive
        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        event_i = 8'h03;
        wr(12'h7C0, 32'h8);
        event_i = 8'h01;
        rd(12'h7C0, v); vecs++;
        if (v !== 32'h8) begin errs++; $display("FAIL set_wins got %h want %h", v, 32'h8); end
        wr(12'h7C1, 32'h0);
        wr(12'h7C0, 32'h8);
        step();
        vecs++;
        if (ovf_irq_o !== 1'b0) begin errs++; $display("FAIL irq_off got %b want 0", ovf_irq_o); end
    endtask

    task automatic test_write_suppress_inhibit();
        logic [31:0] v;
        wr(12'hB80, 32'h5);
        wr(12'hB00, 32'h100);
        rd(12'hB00, v); vecs++;
        if (v !== 32'h100) begin errs++; $display("FAIL wr_no_inc got %h want %h", v, 32'h100); end
        step();
        rd(12'hB00, v); vecs++;
        if (v !== 32'h101) begin errs++; $display("FAIL wr_then_inc got %h want %h", v, 32'h101); end
        rd(12'hB80, v); vecs++;
        if (v !== 32'h5) begin errs++; $display("FAIL hi_kept got %h want %h", v, 32'h5); end
        instret_incr_i = 1'b1;
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, v); vecs++;
        if (v !== 32'h7D) begin errs++; $display("FAIL inh_mask got %h want %h", v, 32'h7D); end
        wr(12'h320, 32'h5);
        rd(12'hB00, v); vecs++;
        if (v !== 32'h102) begin errs++; $display("FAIL inh_old_cy got %h want %h", v, 32'h102); end
        rd(12'hB02, v); vecs++;
        if (v !== 32'd1) begin errs++; $display("FAIL inh_old_ir got %h want %h", v, 32'd1); end
        repeat (3) step();
        rd(12'hB00, v); vecs++;
        if (v !== 32'h102) begin errs++; $display("FAIL cy_frozen got %h want %h", v, 32'h102); end
        rd(12'hB02, v); vecs++;
        if (v !== 32'd1) begin errs++; $display("FAIL ir_frozen got %h want %h", v, 32'd1); end
        wr(12'h320, 32'h0);
        rd(12'hB00, v); vecs++;
        if (v !== 32'h102) begin errs++; $display("FAIL cy_wr_cycle got %h want %h", v, 32'h102); end
        step();
        rd(12'hB00, v); vecs++;
        if (v !== 32'h103) begin errs++; $display("FAIL cy_resume got %h want %h", v, 32'h103); end
        rd(12'hB02, v); vecs++;
        if (v !== 32'd2) begin errs++; $display("FAIL ir_resume got %h want %h", v, 32'd2); end
        instret_incr_i = 1'b0;
        wr(12'hC00, 32'h0);
        rd(12'hB00, v); vecs++;
        if (v !== 32'h104) begin errs++; $display("FAIL ro_ignored got %h want %h", v, 32'h104); end
    endtask

    task automatic test_bypass_decode();
        we_i = 1'b1; waddr_i = 12'h340; wdata_i = 32'hDEAD_BEEF;
        raddr_i = 12'h340;
        #1; vecs++;
        if (rhit_o !== 1'b0 || rdata_o !== 32'h0) begin
            errs++; $display("FAIL unowned got hit=%b data=%h want 0/0", rhit_o, rdata_o);
        end
        waddr_i = 12'h320; wdata_i = 32'h1; raddr_i = 12'h320;
        #1; vecs++;
        if (rhit_o !== 1'b1 || rdata_o !== 32'h1) begin
            errs++; $display("FAIL bypass got hit=%b data=%h want 1/1", rhit_o, rdata_o);
        end
        we_i = 1'b0;
        #1; vecs++;
        if (rdata_o !== 32'h0) begin errs++; $display("FAIL no_bypass got %h want 0", rdata_o); end
        raddr_i = 12'hB07;
        #1; vecs++;
        if (rhit_o !== 1'b0 || rdata_o !== 32'h0) begin
            errs++; $display("FAIL unimpl_hpm got hit=%b data=%h want 0/0", rhit_o, rdata_o);
        end
        raddr_i = 12'hB01;
        #1; vecs++;
        if (rhit_o !== 1'b0) begin errs++; $display("FAIL time_unowned got hit=%b want 0", rhit_o); end
        step();
    endtask

    initial begin
        rst_i = 1'b1;
        instret_incr_i = 1'b0;
        event_i = '0;
        we_i = 1'b0;
        waddr_i = '0;
        wdata_i = '0;
        raddr_i = '0;
        #1;
        test_reset();
        test_event();
        test_overflow();
        test_write_suppress_inhibit();
        test_bypass_decode();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/csr_hpm_counters.md
CSR_HPM_COUNTERS -- requirements
Module: csr_hpm_counters

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, meaning the number of programmable counters mhpmcounter3..(3+NUM_HPM-1); legal range 0..29.
REQ-002 SHALL have parameter CNT_WIDTH, default 64, meaning the implemented counter width; legal range 33..64; bits above CNT_WIDTH read as zero.
REQ-003 SHALL have parameter NUM_EVENTS, default 8, meaning the number of event inputs; legal range 1..31.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, the reset; synchronous and active-high.
REQ-006 SHALL have port instret_incr_i, input, 1, one instruction retired this cycle.
REQ-007 SHALL have port event_i, input, NUM_EVENTS, per-cycle event strobes, level-sampled each cycle.
REQ-008 SHALL have port we_i, input, 1, CSR write enable from writeback.
REQ-009 SHALL have port waddr_i, input, 12, CSR write address.
REQ-010 SHALL have port wdata_i, input, 32, CSR write data.
REQ-011 SHALL have port raddr_i, input, 12, CSR read address.
REQ-012 SHALL have port rdata_o, output, 32, combinational read data.
REQ-013 SHALL have port rhit_o, output, 1, raddr_i decodes to a CSR owned by this block.
REQ-014 SHALL have port ovf_irq_o, output, 1, registered counter-overflow interrupt request.

Function
REQ-015 SHALL implement mcycle (0xB00/0xB80 hi), minstret (0xB02/0xB82 hi), mhpmcounterN (0xB00+N / 0xB80+N, N=3..2+NUM_HPM), each CNT_WIDTH bits.
REQ-016 SHALL provide read-only user shadows at 0xC00+k / 0xC80+k returning the same value as 0xB00+k / 0xB80+k; writes to them are ignored.
REQ-017 SHALL implement mcountinhibit (0x320): bit0 CY, bit2 IR, bit N for each implemented HPM; other bits read zero.
REQ-018 SHALL implement mhpmeventN (0x320+N): 5-bit field wdata_i[4:0], upper bits read zero; value k in 1..NUM_EVENTS selects event_i[k-1]; 0 or >NUM_EVENTS counts nothing.
REQ-019 SHALL implement mhpmovf (0x7C0): sticky overflow bits at the same bit positions as mcountinhibit; write-1-to-clear.
REQ-020 SHALL implement mhpmovfen (0x7C1): overflow interrupt enable per bit position as in REQ-019; read/write.
REQ-021 SHALL increment each cycle when not inhibited: mcycle by 1; minstret by 1 if instret_incr_i; mhpmcounterN by 1 if its selected event is high.
REQ-022 SHALL, on a write to a counter's low word, replace bits [31:0], keep the upper bits, and suppress that counter's increment in that cycle; likewise for the high word with bits [CNT_WIDTH-1:32].
REQ-023 SHALL wrap counters from all-ones (2^CNT_WIDTH-1) to zero, and on that wrap set the counter's mhpmovf bit in the same edge.
REQ-024 SHALL let a hardware overflow set win over a simultaneous write-1-to-clear of the same mhpmovf bit.
REQ-025 SHALL drive ovf_irq_o = |(mhpmovf & mhpmovfen), registered one cycle after the mhpmovf/mhpmovfen update.
REQ-026 SHALL give a newly written mcountinhibit or mhpmevent effect from the next cycle; increments in the write cycle use the old values.
REQ-027 SHALL return, on read, the pre-edge register value, except when we_i=1 and waddr_i==raddr_i, where rdata_o=wdata_i (bypass).
REQ-028 SHALL return rdata_o=0 and rhit_o=0 for unowned addresses and for unimplemented HPM indices.
REQ-029 SHALL ignore writes to unowned or read-only addresses without side effects.

Reset
REQ-030 SHALL, with rst_i high at an edge, clear all counters, mhpmevent, mhpmovf, mhpmovfen, mcountinhibit and ovf_irq_o to zero, overriding any same-cycle write or increment.
REQ-031 SHALL resume counting on the first edge after rst_i deasserts (mcycle=1 one edge after release).

Verification
REQ-032 Reset release, 10 idle cycles -> mcycle=10, minstret=0, ovf_irq_o=0, rdata_o(0xC00)=10.
REQ-033 Write mhpmevent3=2, toggle event_i[1] high for 5 cycles, event_i[0] high throughout -> mhpmcounter3=5; event 1 is ignored.
REQ-034 Write 0xFFFFFFFF to 0xB83 and 0xB03 (CNT_WIDTH=64), mhpmovfen=0x8, event selected and active -> one edge later counter=0 and mhpmovf[3]=1, ovf_irq_o=1 the following cycle; write 0x8 to 0x7C0 -> irq drops one cycle after the clear.
REQ-035 Write mcycle low=0x100 while running -> next read=0x100 (no +1 in write cycle), then 0x101; upper word unchanged.
REQ-036 Set mcountinhibit=0x5 -> mcycle and minstret frozen with instret_incr_i=1; clear -> both resume next cycle.
REQ-037 we_i=1, waddr_i=raddr_i=0x340-range unowned -> rhit_o=0, rdata_o=0; waddr_i=raddr_i=0x320, wdata_i=0x1 -> rdata_o=0x1 same cycle.
